// File: rtl/fib_stream_scheduler.sv
// fib_stream_scheduler: round-robin shared Fibonacci term engine streaming terms over valid/ready
module fib_stream_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = 8,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] req_cnt,
   input  logic [WIDTH-1:0]      max_value,
   output logic [NREQ-1:0]       gnt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [ID_W-1:0]       out_id,
   output logic                  out_last,
   output logic                  out_ovf,
   output logic                  busy
);
   localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, RUN = 2'd2;
   logic [1:0] state;
   logic [ID_W-1:0] rr, id, pick;
   logic [CNT_W-1:0] rem;
   logic [WIDTH-1:0] lim, a, b;
   logic bc, run, hs, exceed, rem_one;
   logic [WIDTH:0] sum;
   function automatic logic [ID_W-1:0] wrap(input int v);
      return ID_W'(v % NREQ);
   endfunction
   // Scanning downward lets the first set bit at or after rr win the last write.
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         pick = req[wrap(int'(rr) + i)] ? wrap(int'(rr) + i) : pick;
   end
   assign run       = state == RUN;
   assign sum       = {1'b0, a} + {1'b0, b};
   assign rem_one   = rem == CNT_W'(1);
   assign exceed    = (b > lim) | bc;
   assign hs        = run & out_ready;
   assign out_valid = run;
   assign out_data  = a;
   assign out_id    = id;
   assign out_last  = run & (rem_one | exceed);
   assign out_ovf   = run & exceed & ~rem_one;
   assign busy      = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         rr    <= '0;
         id    <= '0;
         rem   <= '0;
         lim   <= '0;
         a     <= '0;
         b     <= '0;
         bc    <= 1'b0;
      end else begin
         gnt <= '0;
         if (state == IDLE && |req) begin
            state <= GRANT;
            gnt   <= NREQ'(1) << pick;
            id    <= pick;
            rr    <= wrap(int'(pick) + 1);
            rem   <= req_cnt[pick*CNT_W +: CNT_W];
            lim   <= max_value;
            a     <= '0;
            b     <= WIDTH'(1);
            bc    <= 1'b0;
         end else if (state == GRANT) begin
            state <= (rem == '0) ? IDLE : RUN;
         end else if (hs) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            bc    <= sum[WIDTH];
            rem   <= rem - CNT_W'(1);
            state <= out_last ? IDLE : RUN;
         end
      end
   end
endmodule
